line_buffer_scheduler: RTL and testbench
========================================

// Module: line_buffer_scheduler
// PURPOSE
//  Sequences the 4-bank circular line buffer between the UART FIFO importer (writer) and a 3x3 window filter (reader).
//  Tracks bank occupancy, rotates write/read bank pointers, streams column addresses for 3-line reads, and issues
//  one-cycle line requests that drive the importer's interrupt input. Valid-only convolution: rows 1..IMG_H-2.
// PARAMETERS
//  LINE_W       512  bytes per line (columns per row)
//  IMG_H        512  lines per frame
//  ADDR_W       9    column address width, clog2(LINE_W)
//  PRIME_LINES  4    lines the importer loads unrequested at frame start (equals bank count; bank count fixed at 4)
// PORTS
//  clk            in   1       clock
//  reset          in   1       asynchronous, active-high
//  start          in   1       pulse: begin frame; ignored unless idle
//  wr_line_done   in   1       pulse: importer finished writing one line into wr_bank
//  rd_ready       in   1       filter accepts a column this cycle
//  wr_bank        out  2       bank the importer writes next
//  rd_bank_top    out  2       bank holding row r-1
//  rd_bank_mid    out  2       bank holding row r
//  rd_bank_bot    out  2       bank holding row r+1
//  rd_addr        out  ADDR_W  column address for all three read banks
//  rd_en          out  1       read strobe: (state==S_PROC) && rd_ready, combinational
//  out_row        out  9       centre row r currently processed
//  line_req       out  1       one-cycle pulse: request next line (to importer interrupt)
//  busy           out  1       state != S_IDLE
//  frame_done     out  1       one-cycle pulse after last row streamed
//  err_overrun    out  1       sticky: line written with all 4 banks occupied; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; wr_ptr=rd_base=0, occ=0, req_cnt=0, row_cnt=0, rd_addr=0, out_row=0, state S_IDLE.
//  Pointers: wr_bank=wr_ptr; top=rd_base, mid=rd_base+1, bot=rd_base+2 (all mod 4, natural 2-bit wrap).
//  Occupancy occ (0..4), updated every cycle in all non-idle states:
//   - wr_line_done: wr_ptr+=1, occ+=1.  drop (S_ADV): rd_base+=1, occ-=1.  Both same cycle: occ unchanged.
//   - wr_line_done with occ==4 and no drop: set err_overrun, occ stays 4, wr_ptr still advances.
//   - wr_line_done in S_IDLE: ignored (no pointer/occ change).
//  FSM:
//   S_IDLE : start -> S_WAIT; req_cnt<=PRIME_LINES, row_cnt<=0, out_row<=1, rd_addr<=0.
//   S_WAIT : occ>=3 (counting a wr_line_done in the same cycle is not required) -> S_PROC.
//   S_PROC : each cycle with rd_en, rd_addr+=1; rd_en at rd_addr==LINE_W-1 -> rd_addr<=0, S_ADV.
//            rd_ready low stalls rd_addr indefinitely.
//   S_ADV  : single cycle; drop oldest line; row_cnt+=1, out_row+=1.
//            If req_cnt<IMG_H: line_req=1 this cycle, req_cnt+=1.
//            If row_cnt+1==IMG_H-2 -> S_DONE else -> S_WAIT.
//   S_DONE : frame_done=1 for one cycle; occ<=0, wr_ptr<=0, rd_base<=0; -> S_IDLE.
//  Latency: first rd_en possible 1 cycle after occ reaches 3; per row LINE_W rd_en cycles + 1 S_ADV + >=1 S_WAIT.
//  line_req and frame_done are registered outputs; they assert in the cycle after the S_ADV / S_DONE decision.
//  Counters: req_cnt 10 bit (reaches 512), row_cnt 9 bit, occ 3 bit; no wrap within a frame.
//  Async reset mid-frame returns to reset state immediately; no partial frame_done; err_overrun cleared.
// STRUCTURE
//  Package lb_sched_pkg: state encoding localparams (S_IDLE..S_DONE, 3 bit), N_BANKS=4, BANK_W=2.
//  Sub-module lb_occupancy_tracker: wr_ptr, rd_base, occ, err_overrun; inputs inc/drop/enable.
//  Top holds FSM, rd_addr, row/req counters, output registers.
// TESTING
//  1 start, 4 wr_line_done pulses, rd_ready=1 -> rd_en 512 cycles, banks top/mid/bot=0/1/2, one line_req, out_row 1->2.
//  2 Full frame IMG_H=512 -> exactly 508 line_req pulses (req_cnt 4->512), 510 rows, one frame_done, busy falls after it.
//  3 rd_ready toggled 50% in S_PROC -> rd_addr advances only on rd_en; still exactly 512 rd_en per row.
//  4 wr_line_done coincident with S_ADV drop at occ=3 -> occ stays 3, wr_ptr and rd_base both +1.
//  5 5th wr_line_done before any drop -> err_overrun=1 and sticky until reset; wr_bank wraps 3->0.
//  6 Assert reset at rd_addr=200 of row 7 -> all outputs 0 immediately; new start runs a clean frame.

Source files
------------

// File: rtl/lb_sched_pkg.sv
// Shared types and constants for the line buffer scheduler and its occupancy tracker.
package lb_sched_pkg;

    localparam int N_BANKS = 4;
    localparam int BANK_W  = 2;
    localparam int OCC_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_PROC = 3'd2,
        S_ADV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/lb_occupancy_tracker.sv
// Write/read bank pointers and line occupancy of the 4-bank circular line buffer,
// with a sticky overrun flag for a line written into a full buffer.
module lb_occupancy_tracker
    import lb_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              inc,
    input  logic              drop,
    input  logic              clear,
    output logic [BANK_W-1:0] wr_ptr,
    output logic [BANK_W-1:0] rd_base,
    output logic [OCC_W-1:0]  occ,
    output logic              err_overrun
);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(N_BANKS);

    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0] rd_base_q, rd_base_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              err_q, err_d;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_base_d = rd_base_q;
        occ_d     = occ_q;
        err_d     = err_q;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_base_d = '0;
            occ_d     = '0;
        end else if (enable) begin
            if (inc)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (drop)
                rd_base_d = rd_base_q + 1'b1;
            // A write into a full buffer still advances the pointer but cannot raise occupancy.
            if (inc && !drop) begin
                if (occ_q == OCC_FULL)
                    err_d = 1'b1;
                else
                    occ_d = occ_q + 1'b1;
            end else if (drop && !inc && occ_q != '0) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_base_q <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_base_q <= rd_base_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign rd_base     = rd_base_q;
    assign occ         = occ_q;
    assign err_overrun = err_q;

endmodule

// File: rtl/line_buffer_scheduler.sv
// Frame sequencer between the UART line importer and the 3x3 window filter:
// waits for three buffered lines, streams one row of columns, drops the oldest line, requests the next.
module line_buffer_scheduler
    import lb_sched_pkg::*;
#(
    parameter int LINE_W      = 512,
    parameter int IMG_H       = 512,
    parameter int ADDR_W      = 9,
    parameter int PRIME_LINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_line_done,
    input  logic              rd_ready,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank_top,
    output logic [BANK_W-1:0] rd_bank_mid,
    output logic [BANK_W-1:0] rd_bank_bot,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [8:0]        out_row,
    output logic              line_req,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(LINE_W - 1);
    localparam logic [9:0]        REQ_MAX   = 10'(IMG_H);
    localparam logic [8:0]        LAST_ROWS = 9'(IMG_H - 2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [8:0]        row_cnt_q, row_cnt_d;
    logic [8:0]        out_row_q, out_row_d;
    logic [9:0]        req_cnt_q, req_cnt_d;
    logic              line_req_q, line_req_d;
    logic              frame_done_q, frame_done_d;

    logic [BANK_W-1:0] wr_ptr;
    logic [BANK_W-1:0] rd_base;
    logic [OCC_W-1:0]  occ;
    logic [8:0]        row_nxt;

    lb_occupancy_tracker u_occ (
        .clk         (clk),
        .reset       (reset),
        .enable      (state_q != S_IDLE),
        .inc         (wr_line_done),
        .drop        (state_q == S_ADV),
        .clear       (state_q == S_DONE),
        .wr_ptr      (wr_ptr),
        .rd_base     (rd_base),
        .occ         (occ),
        .err_overrun (err_overrun)
    );

    assign rd_en   = (state_q == S_PROC) && rd_ready;
    assign row_nxt = row_cnt_q + 9'd1;

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        row_cnt_d    = row_cnt_q;
        out_row_d    = out_row_q;
        req_cnt_d    = req_cnt_q;
        line_req_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    req_cnt_d = 10'(PRIME_LINES);
                    row_cnt_d = '0;
                    out_row_d = 9'd1;
                    rd_addr_d = '0;
                end
            end
            S_WAIT: begin
                if (occ >= 3'd3)
                    state_d = S_PROC;
            end
            S_PROC: begin
                if (rd_en) begin
                    if (rd_addr_q == LAST_COL) begin
                        rd_addr_d = '0;
                        state_d   = S_ADV;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            S_ADV: begin
                row_cnt_d = row_nxt;
                out_row_d = out_row_q + 9'd1;
                if (req_cnt_q < REQ_MAX) begin
                    line_req_d = 1'b1;
                    req_cnt_d  = req_cnt_q + 10'd1;
                end
                // frame_done is registered so it is high for exactly the S_DONE cycle.
                if (row_nxt == LAST_ROWS) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            row_cnt_q    <= '0;
            out_row_q    <= '0;
            req_cnt_q    <= '0;
            line_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            row_cnt_q    <= row_cnt_d;
            out_row_q    <= out_row_d;
            req_cnt_q    <= req_cnt_d;
            line_req_q   <= line_req_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign wr_bank    = wr_ptr;
    // Read banks present zero while idle so the block comes out of reset with all outputs low.
    assign rd_bank_top = busy ? rd_base          : '0;
    assign rd_bank_mid = busy ? rd_base + 2'd1   : '0;
    assign rd_bank_bot = busy ? rd_base + 2'd2   : '0;
    assign rd_addr    = rd_addr_q;
    assign out_row    = out_row_q;
    assign line_req   = line_req_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed bench for line_buffer_scheduler, run on a reduced frame size to keep frames short.
module tb_line_buffer_scheduler;

    localparam int LW = 64;
    localparam int IH = 32;
    localparam int AW = 6;
    localparam int ROWS = IH - 2;
    localparam int REQS = IH - 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          wr_line_done = 1'b0;
    logic          rd_ready = 1'b0;
    logic [1:0]    wr_bank, rd_bank_top, rd_bank_mid, rd_bank_bot;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [8:0]    out_row;
    logic          line_req, busy, frame_done, err_overrun;

    int checks = 0;
    int failures = 0;
    int n_rd_en = 0, n_line_req = 0, n_frame_done = 0, n_addr_err = 0;
    int exp_addr = 0;

    always #5 clk = ~clk;

    line_buffer_scheduler #(.LINE_W(LW), .IMG_H(IH), .ADDR_W(AW), .PRIME_LINES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr_line_done (wr_line_done),
        .rd_ready     (rd_ready),
        .wr_bank      (wr_bank),
        .rd_bank_top  (rd_bank_top),
        .rd_bank_mid  (rd_bank_mid),
        .rd_bank_bot  (rd_bank_bot),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .out_row      (out_row),
        .line_req     (line_req),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_overrun  (err_overrun)
    );

    // Column model: every accepted column must carry the next address in 0..LW-1 order.
    always @(negedge clk) begin
        if (reset) begin
            exp_addr = 0;
        end else begin
            if (rd_en) begin
                n_rd_en++;
                if (int'(rd_addr) != exp_addr) n_addr_err++;
                exp_addr = (exp_addr + 1) % LW;
            end
            if (line_req)   n_line_req++;
            if (frame_done) n_frame_done++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_wr();
        wr_line_done = 1'b1;
        step();
        wr_line_done = 1'b0;
    endtask

    task automatic apply_reset();
        start = 1'b0;
        wr_line_done = 1'b0;
        rd_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, int'({wr_bank, rd_bank_top, rd_bank_mid, rd_bank_bot, rd_addr, rd_en, out_row,
                       line_req, busy, frame_done, err_overrun}), 0);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Acts as the importer (answers each line_req with one line) until frame_done or abort point.
    task automatic run_frame(input bit toggle, input int abort_row, output bit aborted, output bit done);
        aborted = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done && !aborted; c++) begin
            if (abort_row > 0 && busy && int'(out_row) == abort_row && rd_addr == AW'(20)) begin
                aborted = 1'b1;
            end else begin
                rd_ready = toggle ? c[0] : 1'b1;
                wr_line_done = line_req;
                step();
                if (frame_done) done = 1'b1;
            end
        end
        wr_line_done = 1'b0;
    endtask

    initial begin
        int b_rd, b_lr, b_fd;
        bit ab, dn, hit;

        step();
        chk_idle("reset_outs");
        reset = 1'b0;
        step();
        chk_idle("post_reset_outs");

        // T1: first row, then the remainder of the frame (T2)
        b_rd = n_rd_en; b_lr = n_line_req; b_fd = n_frame_done;
        begin_frame();
        chk("start_busy", int'(busy), 1);
        chk("start_out_row", int'(out_row), 1);
        repeat (4) pulse_wr();
        chk("prime_wr_wrap", int'(wr_bank), 0);
        chk("row1_banks", int'({rd_bank_top, rd_bank_mid, rd_bank_bot}), 6'b00_01_10);
        rd_ready = 1'b1;
        for (int c = 0; c < 1000 && n_line_req == b_lr; c++) step();
        rd_ready = 1'b0;
        chk("row1_rd_en", n_rd_en - b_rd, LW);
        chk("row1_line_req", n_line_req - b_lr, 1);
        chk("row1_out_row", int'(out_row), 2);
        chk("row2_banks", int'({rd_bank_top, rd_bank_mid, rd_bank_bot}), 6'b01_10_11);
        pulse_wr();
        run_frame(1'b0, 0, ab, dn);
        chk("t2_done_seen", int'(dn), 1);
        chk("t2_last_out_row", int'(out_row), IH - 1);
        chk("t2_busy_at_done", int'(busy), 1);
        step();
        chk("t2_busy_after", int'(busy), 0);
        chk("t2_fd_pulse_low", int'(frame_done), 0);
        chk("t2_line_reqs", n_line_req - b_lr, REQS);
        chk("t2_rd_en", n_rd_en - b_rd, ROWS * LW);
        chk("t2_frame_done", n_frame_done - b_fd, 1);
        chk("t2_no_overrun", int'(err_overrun), 0);
        chk("t2_addr_err", n_addr_err, 0);

        // T3: stalls hold the column address; toggled rd_ready over a full frame
        b_rd = n_rd_en; b_lr = n_line_req; b_fd = n_frame_done;
        begin_frame();
        repeat (4) pulse_wr();
        rd_ready = 1'b1;
        repeat (5) step();
        chk("t3_addr_run", int'(rd_addr), 5);
        rd_ready = 1'b0;
        repeat (3) step();
        chk("t3_addr_stall", int'(rd_addr), 5);
        run_frame(1'b1, 0, ab, dn);
        chk("t3_done_seen", int'(dn), 1);
        step();
        chk("t3_rd_en", n_rd_en - b_rd, ROWS * LW);
        chk("t3_line_reqs", n_line_req - b_lr, REQS);
        chk("t3_frame_done", n_frame_done - b_fd, 1);
        chk("t3_addr_err", n_addr_err, 0);

        // T4: line written during the drop cycle at occupancy 3
        begin_frame();
        rd_ready = 1'b0;
        repeat (3) pulse_wr();
        step();
        rd_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (busy && rd_addr == AW'(LW - 1)) hit = 1'b1;
            else step();
        end
        chk("t4_reach_last_col", int'(hit), 1);
        step();
        wr_line_done = 1'b1;
        rd_ready = 1'b0;
        step();
        wr_line_done = 1'b0;
        chk("t4_wr_bank", int'(wr_bank), 0);
        chk("t4_rd_top", int'(rd_bank_top), 1);
        chk("t4_line_req", int'(line_req), 1);
        pulse_wr();
        chk("t4_occ4_no_err", int'(err_overrun), 0);
        pulse_wr();
        chk("t4_occ_was_3", int'(err_overrun), 1);
        chk("t4_wr_bank2", int'(wr_bank), 2);
        apply_reset();
        chk_idle("t4_reset_outs");

        // T5: fifth line before any drop
        begin_frame();
        rd_ready = 1'b0;
        repeat (3) pulse_wr();
        chk("t5_wr_bank3", int'(wr_bank), 3);
        pulse_wr();
        chk("t5_wr_wrap", int'(wr_bank), 0);
        chk("t5_no_err", int'(err_overrun), 0);
        pulse_wr();
        chk("t5_err_set", int'(err_overrun), 1);
        chk("t5_wr_bank1", int'(wr_bank), 1);
        repeat (10) step();
        chk("t5_err_sticky", int'(err_overrun), 1);
        apply_reset();
        chk("t5_err_cleared", int'(err_overrun), 0);

        // T6: reset mid-row, then a clean frame
        b_fd = n_frame_done;
        begin_frame();
        repeat (4) pulse_wr();
        run_frame(1'b0, 7, ab, dn);
        chk("t6_abort_point", int'(ab), 1);
        reset = 1'b1;
        #1;
        chk_idle("t6_async_reset_outs");
        step();
        step();
        reset = 1'b0;
        step();
        chk("t6_no_partial_done", n_frame_done - b_fd, 0);
        b_rd = n_rd_en; b_lr = n_line_req; b_fd = n_frame_done;
        begin_frame();
        repeat (4) pulse_wr();
        run_frame(1'b0, 0, ab, dn);
        chk("t6_done_seen", int'(dn), 1);
        step();
        chk("t6_rd_en", n_rd_en - b_rd, ROWS * LW);
        chk("t6_line_reqs", n_line_req - b_lr, REQS);
        chk("t6_frame_done", n_frame_done - b_fd, 1);
        chk("t6_addr_err", n_addr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
